// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter for the single-port data memory
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  input  logic [DW-1:0] mem_read_data,
  output logic          mem_memread,
  output logic          mem_memwrite
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic last, sel, we_r, win, grant;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  // on a tie the port not served last wins; otherwise the lone requester
  assign win = (req0 & req1) ? ~last : req1;
  assign grant = (state == IDLE) & (req0 | req1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    state_nx = grant ? ACCESS : (state == ACCESS) ? RESP : IDLE;
  end
  always_comb begin
    gnt0 = 1'b0;
    gnt0 = (state == ACCESS) & ~sel;
    gnt1 = (state == ACCESS) & sel;
    done0 = (state == RESP) & ~sel;
    done1 = (state == RESP) & sel;
    busy = state != IDLE;
    mem_memread = (state == ACCESS) & ~we_r;
    mem_memwrite = (state == ACCESS) & we_r;
    mem_address = addr_r;
    mem_write_data = wdata_r;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last <= 1'b1;
      sel <= 1'b0;
      we_r <= 1'b0;
      addr_r <= '0;
      wdata_r <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if (grant) begin
        sel <= win;
        we_r <= win ? we1 : we0;
        addr_r <= win ? addr1 : addr0;
        wdata_r <= win ? wdata1 : wdata0;
      end
      if (state == ACCESS) begin
        last <= sel;
        if (!we_r && !sel) rdata0 <= mem_read_data;
        if (!we_r && sel) rdata1 <= mem_read_data;
      end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of grant, timing, round-robin and async reset
module tb_dmem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic gnt0, gnt1, done0, done1, busy, mem_memread, mem_memwrite;
  logic [31:0] rdata0, rdata1, mem_address, mem_write_data, mem_read_data;
  logic [31:0] mem [0:255];
  int tests = 0, fails = 0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite)
  );

  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_address[7:0]];
  always @(posedge clk) if (mem_memwrite) mem[mem_address[7:0]] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one complete access on port p; exp_r0/exp_r1 are the rdata values after it
  task automatic xfer(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_r0, input logic [31:0] exp_r1);
    @(negedge clk);
    if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    else begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    @(negedge clk);
    check("xfer_gnt", {gnt1, gnt0}, p ? 32'd2 : 32'd1);
    check("xfer_strobe", {mem_memwrite, mem_memread}, w ? 32'd2 : 32'd1);
    check("xfer_addr", mem_address, a);
    if (w) check("xfer_wdata", mem_write_data, d);
    @(negedge clk);
    check("xfer_done", {done1, done0, gnt1, gnt0}, p ? 32'h8 : 32'h4);
    check("xfer_resp_strobe", {mem_memwrite, mem_memread}, 32'd0);
    check("xfer_rdata0", rdata0, exp_r0);
    check("xfer_rdata1", rdata1, exp_r1);
    req0 = 0; req1 = 0;
    @(negedge clk);
    check("xfer_idle", {busy, done1, done0}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h0A] = 32'hABCD0000;
    mem[8'h20] = 32'h22220000;
    @(negedge clk);
    check("rst_ctrl", {gnt0, gnt1, done0, done1, busy, mem_memread, mem_memwrite}, 32'd0);
    check("rst_data", rdata0 | rdata1 | mem_address | mem_write_data, 32'd0);
    rst_n = 1;
    // single read, write then read-back on port 1
    xfer(0, 0, 32'h0A, 32'h0, 32'hABCD0000, 32'h0);
    xfer(1, 1, 32'h03, 32'h10000001, 32'hABCD0000, 32'h0);
    check("mem_written", mem[8'h03], 32'h10000001);
    xfer(1, 0, 32'h03, 32'h0, 32'hABCD0000, 32'h10000001);
    // simultaneous requests after reset alternate 0,1,0,1
    pulse_reset();
    addr0 = 32'h0A; addr1 = 32'h03; we0 = 0; we1 = 0;
    req0 = 1; req1 = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("tie_gnt", {gnt1, gnt0}, k[0] ? 32'd2 : 32'd1);
      check("tie_strobes", {mem_memwrite, mem_memread}, 32'd1);
      @(negedge clk);
      check("tie_done", {done1, done0}, k[0] ? 32'd2 : 32'd1);
      if (k == 3) begin req0 = 0; req1 = 0; end
      @(negedge clk);
      check("tie_idle", {32'(busy)}, 32'd0);
    end
    check("tie_rdata", rdata0 ^ rdata1, 32'hABCD0000 ^ 32'h10000001);
    // addr0 changes during ACCESS; latched value must hold
    @(negedge clk); req0 = 1; we0 = 0; addr0 = 32'h20;
    @(negedge clk); addr0 = 32'h30;
    #1 check("stable_addr", mem_address, 32'h20);
    @(negedge clk);
    check("stable_rdata", rdata0, 32'h22220000);
    req0 = 0;
    @(negedge clk);
    // reset mid-write: port 0 was served last, so a restored pointer favours 0
    req0 = 1; we0 = 1; addr0 = 32'h05; wdata0 = 32'h55;
    @(negedge clk);
    check("midrst_pre", {mem_memwrite, gnt0, busy}, 32'h7);
    #2 rst_n = 0;
    #1 check("midrst_async", {mem_memwrite, gnt0, busy}, 32'd0);
    req0 = 0;
    @(negedge clk);
    check("midrst_nodone", {done0, done1, busy}, 32'd0);
    check("midrst_nowrite", mem[8'h05], 32'h0);
    rst_n = 1;
    addr0 = 32'h0A; addr1 = 32'h03; we0 = 0; we1 = 0;
    req0 = 1; req1 = 1;
    @(negedge clk);
    check("midrst_tie", {gnt1, gnt0}, 32'd1);
    @(negedge clk);
    req0 = 0; req1 = 0;
    @(negedge clk);
    // long idle: nothing moves
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_ctrl", {gnt0, gnt1, done0, done1, busy, mem_memread, mem_memwrite}, 32'd0);
      check("idle_rdata0", rdata0, 32'hABCD0000);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
